// File: rtl/player_pkg.sv
// Shared types and constants for the per-player motion/animation sequencer.
package player_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        JUMP  = 3'd2,
        PRONE = 3'd3,
        DEAD  = 3'd4
    } player_state_t;

    localparam logic [3:0] IMG_STAND = 4'd0;
    localparam logic [3:0] IMG_RUN_A = 4'd1;
    localparam logic [3:0] IMG_RUN_B = 4'd2;
    localparam logic [3:0] IMG_JUMP  = 4'd3;
    localparam logic [3:0] IMG_PRONE = 4'd4;
    localparam logic [3:0] IMG_SHOOT = 4'd5;

    localparam int SPRITE_W = 30;
    localparam int SPRITE_H = 50;
    localparam int SCREEN_W = 640;
    localparam int FLOOR_Y  = 430;

endpackage

// File: rtl/player_jump_unit.sv
// Vertical jump physics: vy register, y integration, ceiling/ground clamp and landing detect.
module player_jump_unit
    import player_pkg::*;
#(
    parameter int GROUND_Y = 380,
    parameter int JUMP_V0  = 12,
    parameter int GRAVITY  = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       step,
    input  logic       abort,
    input  logic       respawn,
    output logic [9:0] pos_y,
    output logic       landed
);

    localparam logic signed [5:0]  VY_START = 6'(-JUMP_V0);
    localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);

    logic signed [5:0]  vy_q;
    logic signed [5:0]  vy_cur;
    logic signed [5:0]  vy_new;
    logic signed [6:0]  vy_sum;
    logic signed [10:0] y_next;

    // The launch tick already integrates with the initial speed.
    always_comb begin
        vy_cur = start ? VY_START : vy_q;
        y_next = $signed({1'b0, pos_y}) + $signed({{5{vy_cur[5]}}, vy_cur});
        vy_sum = $signed({vy_cur[5], vy_cur}) + $signed(7'(GRAVITY));
        if (vy_sum > 7'sd31) vy_new = 6'sd31;
        else                 vy_new = vy_sum[5:0];
        landed = (start || step) && (y_next >= GROUND_S);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pos_y <= 10'(GROUND_Y);
            vy_q  <= '0;
        end else if (respawn) begin
            pos_y <= 10'(GROUND_Y);
            vy_q  <= '0;
        end else if (abort) begin
            vy_q <= '0;
        end else if (start || step) begin
            if (landed) begin
                pos_y <= 10'(GROUND_Y);
                vy_q  <= '0;
            end else begin
                pos_y <= y_next[10] ? 10'd0 : y_next[9:0];
                vy_q  <= vy_new;
            end
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Per-player stand/run/jump/prone/dead sequencer, advanced once per frame_tick rising edge.
// Optional PLAYER_RESPAWN_BLINK_EN: blinking, hit-immune window after respawn.
module player_ctrl
    import player_pkg::*;
#(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = SCREEN_W - SPRITE_W,
    parameter int GROUND_Y       = FLOOR_Y - SPRITE_H,
    parameter int SPAWN_X        = 40,
    parameter int X_STEP         = 2,
    parameter int JUMP_V0        = 12,
    parameter int GRAVITY        = 1,
    parameter int ANIM_DIV       = 6,
    parameter int RESPAWN_FRAMES = 90
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_tick,
    input  logic          key_left,
    input  logic          key_right,
    input  logic          key_jump,
    input  logic          key_down,
    input  logic          key_fire,
    input  logic          hit,
    output logic          show_player,
    output logic [9:0]    player_pos_x,
    output logic [9:0]    player_pos_y,
    output logic [3:0]    player_current_image,
    output logic          player_face_dir,
    output logic          player_dead,
    output player_state_t dbg_state
);

    localparam int TIMER_W = $clog2(RESPAWN_FRAMES + 1);
    localparam int ANIM_W  = $clog2(ANIM_DIV + 1);

    player_state_t      state_q, state_d;
    logic [9:0]         x_q, x_d, x_moved;
    logic               face_q, face_d, show_q, show_d, tick_q;
    logic [3:0]         img_q, img_d, idle_img;
    logic [ANIM_W-1:0]  anim_q, anim_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               tick, horiz, hit_ok;
    logic               jump_start, jump_step, jump_abort, jump_respawn, jump_landed;
    int                 x_int;

    assign tick     = frame_tick && !tick_q;
    assign horiz    = key_left ^ key_right;
    assign idle_img = key_fire ? IMG_SHOOT : IMG_STAND;

    always_comb begin
        x_int = int'(x_q) + (key_right ? X_STEP : -X_STEP);
        if (x_int < X_MIN)      x_int = X_MIN;
        else if (x_int > X_MAX) x_int = X_MAX;
        x_moved = 10'(x_int);
    end

`ifdef PLAYER_RESPAWN_BLINK_EN
    logic [TIMER_W-1:0] inv_q, inv_d;
    logic [1:0]         blink_q, blink_d;
    assign hit_ok = hit && (inv_q == '0);
`else
    assign hit_ok = hit;
`endif

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        face_d       = face_q;
        img_d        = img_q;
        show_d       = show_q;
        anim_d       = anim_q;
        timer_d      = timer_q;
        jump_start   = 1'b0;
        jump_step    = 1'b0;
        jump_abort   = 1'b0;
        jump_respawn = 1'b0;
`ifdef PLAYER_RESPAWN_BLINK_EN
        inv_d   = inv_q;
        blink_d = blink_q;
`endif
        if (tick) begin
            if (state_q == DEAD) begin
                if (timer_q == '0) begin
                    state_d      = IDLE;
                    x_d          = 10'(SPAWN_X);
                    face_d       = 1'b1;
                    img_d        = IMG_STAND;
                    show_d       = 1'b1;
                    jump_respawn = 1'b1;
`ifdef PLAYER_RESPAWN_BLINK_EN
                    inv_d   = TIMER_W'(RESPAWN_FRAMES);
                    blink_d = '0;
`endif
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end else begin
`ifdef PLAYER_RESPAWN_BLINK_EN
                if (inv_q != '0) begin
                    inv_d   = inv_q - 1'b1;
                    blink_d = blink_q + 1'b1;
                    if (inv_q == TIMER_W'(1)) show_d = 1'b1;
                    else if (blink_q == 2'd3) show_d = !show_q;
                end
`endif
                if (hit_ok) begin
                    state_d    = DEAD;
                    show_d     = 1'b0;
                    timer_d    = TIMER_W'(RESPAWN_FRAMES - 1);
                    jump_abort = 1'b1;
                end else begin
                    case (state_q)
                        IDLE, RUN: begin
                            if (key_jump) begin
                                state_d    = JUMP;
                                img_d      = IMG_JUMP;
                                jump_start = 1'b1;
                            end else if (key_down) begin
                                state_d = PRONE;
                                img_d   = IMG_PRONE;
                                if (horiz) face_d = key_right;
                            end else if (horiz) begin
                                state_d = RUN;
                                x_d     = x_moved;
                                face_d  = key_right;
                                if (state_q != RUN) begin
                                    anim_d = '0;
                                    img_d  = IMG_RUN_A;
                                end else if (anim_q == ANIM_W'(ANIM_DIV - 1)) begin
                                    anim_d = '0;
                                    img_d  = (img_q == IMG_RUN_A) ? IMG_RUN_B : IMG_RUN_A;
                                end else begin
                                    anim_d = anim_q + 1'b1;
                                end
                            end else begin
                                state_d = IDLE;
                                img_d   = idle_img;
                            end
                        end
                        PRONE: begin
                            if (!key_down) begin
                                state_d = IDLE;
                                img_d   = idle_img;
                            end else if (horiz) begin
                                face_d = key_right;
                            end
                        end
                        JUMP: begin
                            jump_step = 1'b1;
                            if (horiz) begin
                                x_d    = x_moved;
                                face_d = key_right;
                            end
                            // Landing picks the ground state from this tick's keys.
                            if (jump_landed) begin
                                if (horiz) begin
                                    state_d = RUN;
                                    anim_d  = '0;
                                    img_d   = IMG_RUN_A;
                                end else begin
                                    state_d = IDLE;
                                    img_d   = idle_img;
                                end
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            x_q     <= 10'(SPAWN_X);
            face_q  <= 1'b1;
            img_q   <= IMG_STAND;
            show_q  <= 1'b1;
            anim_q  <= '0;
            timer_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            face_q  <= face_d;
            img_q   <= img_d;
            show_q  <= show_d;
            anim_q  <= anim_d;
            timer_q <= timer_d;
            tick_q  <= frame_tick;
        end
    end

`ifdef PLAYER_RESPAWN_BLINK_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            inv_q   <= '0;
            blink_q <= '0;
        end else begin
            inv_q   <= inv_d;
            blink_q <= blink_d;
        end
    end
`endif

    player_jump_unit #(
        .GROUND_Y (GROUND_Y),
        .JUMP_V0  (JUMP_V0),
        .GRAVITY  (GRAVITY)
    ) u_jump (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (jump_start),
        .step    (jump_step),
        .abort   (jump_abort),
        .respawn (jump_respawn),
        .pos_y   (player_pos_y),
        .landed  (jump_landed)
    );

    assign show_player          = show_q;
    assign player_pos_x         = x_q;
    assign player_current_image = img_q;
    assign player_face_dir      = face_q;
    assign player_dead          = (state_q == DEAD);
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: run/clamp, jump arc, prone, fire, held tick, death and respawn.
module tb_player_ctrl;
    import player_pkg::*;

    logic          Clk, Reset, frame_tick;
    logic          key_left, key_right, key_jump, key_down, key_fire, hit;
    logic          show_player, player_face_dir, player_dead;
    logic [9:0]    player_pos_x, player_pos_y;
    logic [3:0]    player_current_image;
    player_state_t dbg_state;
    int            n_cmp, n_fail;
    int            exp_v;

    player_ctrl dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .frame_tick           (frame_tick),
        .key_left             (key_left),
        .key_right            (key_right),
        .key_jump             (key_jump),
        .key_down             (key_down),
        .key_fire             (key_fire),
        .hit                  (hit),
        .show_player          (show_player),
        .player_pos_x         (player_pos_x),
        .player_pos_y         (player_pos_y),
        .player_current_image (player_current_image),
        .player_face_dir      (player_face_dir),
        .player_dead          (player_dead),
        .dbg_state            (dbg_state)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_keys(input logic l, input logic r, input logic j,
                            input logic d, input logic f, input logic h);
        key_left  = l;
        key_right = r;
        key_jump  = j;
        key_down  = d;
        key_fire  = f;
        hit       = h;
    endtask

    // Called at a falling edge; returns at a falling edge one idle cycle after the tick.
    task automatic do_tick(input int hold = 1);
        frame_tick = 1'b1;
        repeat (hold) @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
    endtask

    task automatic check_home(input string tag);
        check({tag, "_show"}, 32'(show_player), 32'd1);
        check({tag, "_x"}, 32'(player_pos_x), 32'd40);
        check({tag, "_y"}, 32'(player_pos_y), 32'd380);
        check({tag, "_img"}, 32'(player_current_image), 32'd0);
        check({tag, "_face"}, 32'(player_face_dir), 32'd1);
        check({tag, "_dead"}, 32'(player_dead), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        frame_tick = 1'b0;
        set_keys(0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        #2 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check_home("reset");
        Reset = 1'b1;
        @(negedge Clk);

        repeat (3) do_tick();
        check_home("idle3");

        // Run right 20 ticks: image 1x6, 2x6, 1x6, 2x2
        set_keys(0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            do_tick();
            exp_v = (((i - 1) / 6) % 2 == 0) ? 1 : 2;
            check("run_r_img", 32'(player_current_image), 32'(exp_v));
            check("run_r_x", 32'(player_pos_x), 32'(40 + 2 * i));
        end
        check("run_r_face", 32'(player_face_dir), 32'd1);
        check("run_r_state", 32'(dbg_state), 32'(RUN));

        // Run left 40 ticks from x=80, clamping at 0
        set_keys(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            do_tick();
            exp_v = (80 - 2 * i < 0) ? 0 : 80 - 2 * i;
            check("run_l_x", 32'(player_pos_x), 32'(exp_v));
        end
        check("run_l_face", 32'(player_face_dir), 32'd0);

        set_keys(0, 0, 0, 0, 0, 0);
        do_tick();
        check("stop_state", 32'(dbg_state), 32'(IDLE));
        check("stop_img", 32'(player_current_image), 32'd0);

        // Jump: y = 380 - (12k - k(k-1)/2), lands on tick 25
        set_keys(0, 0, 1, 0, 0, 0);
        do_tick();
        set_keys(0, 0, 0, 0, 0, 0);
        check("jump1_y", 32'(player_pos_y), 32'd368);
        check("jump1_img", 32'(player_current_image), 32'd3);
        check("jump1_state", 32'(dbg_state), 32'(JUMP));
        for (int k = 2; k <= 25; k++) begin
            do_tick();
            check("jump_y", 32'(player_pos_y), 32'(380 - (12 * k - (k * (k - 1)) / 2)));
            check("jump_img", 32'(player_current_image), (k < 25) ? 32'd3 : 32'd0);
        end
        check("land_state", 32'(dbg_state), 32'(IDLE));
        check("land_x", 32'(player_pos_x), 32'd0);

        // Get to x=8 facing left, then idle
        set_keys(0, 1, 0, 0, 0, 0);
        repeat (5) do_tick();
        set_keys(1, 0, 0, 0, 0, 0);
        do_tick();
        set_keys(0, 0, 0, 0, 0, 0);
        do_tick();
        check("pre_x", 32'(player_pos_x), 32'd8);
        check("pre_face", 32'(player_face_dir), 32'd0);

        // Both horizontal keys: no motion, face kept
        set_keys(1, 1, 0, 0, 0, 0);
        do_tick();
        check("both_x", 32'(player_pos_x), 32'd8);
        check("both_face", 32'(player_face_dir), 32'd0);
        check("both_state", 32'(dbg_state), 32'(IDLE));

        // Down plus right: prone, no motion, face turns right
        set_keys(0, 1, 0, 1, 0, 0);
        do_tick();
        check("prone_img", 32'(player_current_image), 32'd4);
        check("prone_x", 32'(player_pos_x), 32'd8);
        check("prone_face", 32'(player_face_dir), 32'd1);
        check("prone_state", 32'(dbg_state), 32'(PRONE));
        set_keys(0, 0, 0, 0, 0, 0);
        do_tick();
        check("unprone_state", 32'(dbg_state), 32'(IDLE));

        // Fire while idle shows the shoot image
        set_keys(0, 0, 0, 0, 1, 0);
        do_tick();
        check("fire_img", 32'(player_current_image), 32'd5);
        set_keys(0, 0, 0, 0, 0, 0);
        do_tick();
        check("nofire_img", 32'(player_current_image), 32'd0);

        // frame_tick held four cycles counts once
        set_keys(0, 1, 0, 0, 0, 0);
        do_tick(4);
        check("held_x", 32'(player_pos_x), 32'd10);
        set_keys(0, 0, 0, 0, 0, 0);
        do_tick();

        // Hit mid-jump, then 90 ticks dead with a stray hit ignored
        set_keys(0, 0, 1, 0, 0, 0);
        do_tick();
        set_keys(0, 0, 0, 0, 0, 0);
        repeat (3) do_tick();
        check("hitjump_y", 32'(player_pos_y), 32'd338);
        set_keys(0, 0, 0, 0, 0, 1);
        do_tick();
        check("hit_dead", 32'(player_dead), 32'd1);
        check("hit_show", 32'(show_player), 32'd0);
        check("hit_state", 32'(dbg_state), 32'(DEAD));
        for (int j = 1; j <= 90; j++) begin
            hit = (j == 45);
            do_tick();
            if (j < 90) begin
                check("dead_dead", 32'(player_dead), 32'd1);
                check("dead_show", 32'(show_player), 32'd0);
            end
        end
        check_home("respawn");

`ifdef PLAYER_RESPAWN_BLINK_EN
        hit = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            do_tick();
            check("blink_show", 32'(show_player), ((t / 4) % 2 == 0) ? 32'd1 : 32'd0);
            check("blink_dead", 32'(player_dead), 32'd0);
        end
        hit = 1'b0;
`else
        hit = 1'b1;
        do_tick();
        hit = 1'b0;
        check("rehit_dead", 32'(player_dead), 32'd1);
        check("rehit_show", 32'(show_player), 32'd0);
`endif

        // Asynchronous reset mid-sequence restores reset values at once
        Reset = 1'b0;
        #1;
        check_home("reset_mid");
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        do_tick();
        check_home("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
